// File: rtl/hilo_div_unit_pkg.sv
// Shared divider definitions: FSM encoding, operand width, divide-by-zero quotient
// and the div alucontrol codes also used by the ALU decoder.
package div_pkg;
  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = '1;

  localparam logic [3:0] ALUCTRL_DIV  = 4'b1010;
  localparam logic [3:0] ALUCTRL_DIVU = 4'b1011;
endpackage

// File: rtl/hilo_div_unit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// remainder, trial-subtract the divisor on WIDTH+1 bits, keep or restore.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);
  logic [WIDTH:0] w_trial;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  assign w_trial = {i_rem, i_quo[WIDTH-1]};
  assign w_diff  = w_trial - {1'b0, i_div};
  // rem < divisor keeps |trial - div| below 2^WIDTH, so bit WIDTH is the borrow
  assign w_ge    = ~w_diff[WIDTH];
  assign o_rem   = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign o_quo   = {i_quo[WIDTH-2:0], w_ge};
endmodule

// File: rtl/hilo_div_unit.sv
// Iterative radix-2 restoring DIV/DIVU unit returning {HI=rem, LO=quo}.
// Define DIV_ZERO_FAST_EN to finish a divide-by-zero one cycle after start.
import div_pkg::*;

module hilo_div_unit #(
  parameter  int WIDTH = DIV_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);
  div_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem, r_quo, r_div;
  logic               r_sign_q, r_sign_r, r_bzero;
  logic               r_ready;
  logic [2*WIDTH-1:0] r_result;

  logic               w_start;
  logic [WIDTH-1:0]   w_a_abs, w_b_abs;
  logic [WIDTH-1:0]   w_rem_n, w_quo_n;
  logic [WIDTH-1:0]   w_hi, w_lo;

  assign w_start = ~rst & (r_state == DIV_IDLE) & start_i & ~annul_i;
  assign busy_o  = w_start | (r_state == DIV_BUSY);

  assign w_a_abs = (signed_i & a_i[WIDTH-1]) ? -a_i : a_i;
  assign w_b_abs = (signed_i & b_i[WIDTH-1]) ? -b_i : b_i;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_rem_n),
    .o_quo (w_quo_n)
  );

  // Divide by zero forces an all-ones LO regardless of the quotient sign
  assign w_hi = r_sign_r ? -w_rem_n : w_rem_n;
  assign w_lo = r_bzero ? DIV_ZERO_QUO : (r_sign_q ? -w_quo_n : w_quo_n);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DIV_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_bzero  <= 1'b0;
      r_ready  <= 1'b0;
      r_result <= '0;
    end else begin
      r_ready <= 1'b0;
      if (annul_i) begin
        r_state <= DIV_IDLE;
      end else begin
        case (r_state)
          DIV_IDLE: if (start_i) begin
            r_rem    <= '0;
            r_cnt    <= '0;
            r_quo    <= w_a_abs;
            r_div    <= w_b_abs;
            r_sign_q <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            r_sign_r <= signed_i & a_i[WIDTH-1];
            r_bzero  <= (b_i == '0);
`ifdef DIV_ZERO_FAST_EN
            if (b_i == '0) begin
              r_result <= {a_i, DIV_ZERO_QUO};
              r_ready  <= 1'b1;
              r_state  <= DIV_DONE;
            end else begin
              r_state  <= DIV_BUSY;
            end
`else
            r_state  <= DIV_BUSY;
`endif
          end
          DIV_BUSY: begin
            r_rem <= w_rem_n;
            r_quo <= w_quo_n;
            r_cnt <= r_cnt + 1'b1;
            // Final iteration: result lands so ready_o pulses during DONE
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
              r_result <= {w_hi, w_lo};
              r_ready  <= 1'b1;
              r_state  <= DIV_DONE;
            end
          end
          DIV_DONE: r_state <= DIV_IDLE;
          default:  r_state <= DIV_IDLE;
        endcase
      end
    end
  end

  assign ready_o  = r_ready;
  assign result_o = r_result;
endmodule

// File: tb/tb_hilo_div_unit.sv
// Scoreboard bench for hilo_div_unit: expected results queued at start, popped on ready_o.
module tb_hilo_div_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, signed_i, annul_i;
  logic [31:0] a_i, b_i;
  logic        busy_o, ready_o;
  logic [63:0] result_o;

  int ntests = 0;
  int nfail  = 0;
  logic [63:0] sb_q[$];
  logic [63:0] last_res;

  hilo_div_unit dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .a_i(a_i), .b_i(b_i), .annul_i(annul_i),
    .busy_o(busy_o), .ready_o(ready_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a; sb = b;
    q = sa / sb; r = sa % sb;
    return {32'(r), 32'(q)};
  endfunction

  always @(negedge clk) begin
    if (!rst && ready_o) begin
      if (sb_q.size() == 0) chk("spurious_ready", {63'd0, ready_o}, 64'd0);
      else chk("result", result_o, sb_q.pop_front());
    end
  end

  function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) return 1;
`endif
    return 33;
  endfunction

  // Starts one divide at the next negedge and follows it to ready_o.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input logic hold);
    int n, nbusy, lat;
    lat = exp_lat(b);
    @(negedge clk);
    start_i = 1'b1; signed_i = sgn; a_i = a; b_i = b;
    #1 chk("busy_start", {63'd0, busy_o}, 64'd1);
    sb_q.push_back(exp);
    n = 0; nbusy = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
      start_i = hold;
      #1;
      if (busy_o) nbusy++;
    end while (!ready_o && n < 200);
    chk("latency", 64'(n), 64'(lat));
    chk("busy_cycles", 64'(nbusy), 64'(lat - 1));
    chk("busy_at_ready", {63'd0, busy_o}, 64'd0);
    start_i = 1'b0;
    last_res = exp;
    @(negedge clk); #1;
    chk("ready_one_cycle", {63'd0, ready_o}, 64'd0);
    chk("idle_after", {63'd0, busy_o}, 64'd0);
    chk("result_hold", result_o, exp);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    rst = 1'b1; start_i = 1'b1; signed_i = 1'b0; annul_i = 1'b0; a_i = 32'd5; b_i = 32'd1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_result", result_o, 64'd0);
    start_i = 1'b0;
    rst = 1'b0;

    do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 1'b0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 1'b0);
    do_div(1'b0, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, 1'b0);
    do_div(1'b1, 32'hFFFF_FF00, 32'd0, {32'hFFFF_FF00, 32'hFFFF_FFFF}, 1'b0);
    do_div(1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'd0}, 1'b0);

    // annul mid-operation: no result, old result kept, then a clean restart
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd1000; b_i = 32'd3;
    @(posedge clk);
    @(negedge clk); start_i = 1'b0;
    repeat (9) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk); annul_i = 1'b0;
    #1;
    chk("annul_busy", {63'd0, busy_o}, 64'd0);
    chk("annul_ready", {63'd0, ready_o}, 64'd0);
    chk("annul_result", result_o, last_res);
    do_div(1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 1'b0);

    // start held high through DONE must produce a single result
    do_div(1'b1, 32'hFFFF_FF9C, 32'd7, model(1'b1, 32'hFFFF_FF9C, 32'd7), 1'b1);

    for (int i = 0; i < 8; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom();
      rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 15)) : $urandom();
      if (rs && rb[31] && i[0]) rb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      do_div(rs, ra, rb, model(rs, ra, rb), 1'b0);
    end

    // reset in the middle of BUSY drops the operation
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd77; b_i = 32'd5;
    @(posedge clk);
    @(negedge clk); start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_ready", {63'd0, ready_o}, 64'd0);
    chk("midrst_result", result_o, 64'd0);
    chk("midrst_busy", {63'd0, busy_o}, 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    do_div(1'b0, 32'd77, 32'd5, {32'd2, 32'd15}, 1'b0);

    chk("queue_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
